// File: rtl/burst_traffic_generator.sv
// burst_traffic_generator
// Shares one memory-controller command port between an incoming write
// stream and an outgoing read stream. Frames are written into a small
// ring of frame buffers. Reads always replay the most recently completed
// frame. Each side may issue at most BURST_LEN commands before it yields.
// A tracker FIFO records every issued command so that completions can be
// steered to the read stream and marked with tlast.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   memrequest_*             command interface to the memory controller
//   write_axis_*             incoming frame stream (valid/ready, tlast ends a frame)
//   read_axis_*              outgoing frame stream; af throttles read issue
//   cmd_error                sticky: a completion arrived with nothing outstanding
//
// state | meaning
// IDLE  | first cycle after reset release, no commands issued
// RD    | issuing reads of the latched read frame
// WR    | issuing writes from the incoming stream
module burst_traffic_generator #(
  parameter int ADDR_WIDTH  = 24,
  parameter int DATA_WIDTH  = 128,
  parameter int FRAME_WORDS = 115200,
  parameter int NUM_FRAMES  = 2,
  parameter int BURST_LEN   = 8,
  parameter int CF_DEPTH    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] memrequest_addr,
  output logic                  memrequest_en,
  output logic                  memrequest_write_enable,
  output logic [DATA_WIDTH-1:0] memrequest_write_data,
  input  logic [DATA_WIDTH-1:0] memrequest_resp_data,
  input  logic                  memrequest_complete,
  input  logic                  memrequest_busy,
  input  logic [DATA_WIDTH-1:0] write_axis_data,
  input  logic                  write_axis_tlast,
  input  logic                  write_axis_valid,
  output logic                  write_axis_ready,
  output logic [DATA_WIDTH-1:0] read_axis_data,
  output logic                  read_axis_tlast,
  output logic                  read_axis_valid,
  input  logic                  read_axis_af,
  input  logic                  read_axis_ready,
  output logic                  cmd_error
);
  localparam int OFF_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int FR_W  = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int BC_W  = $clog2(BURST_LEN + 1);
  localparam int PTR_W = (CF_DEPTH > 1) ? $clog2(CF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(FRAME_WORDS - 1);
  localparam logic [FR_W-1:0]  FR_LAST  = FR_W'(NUM_FRAMES - 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BURST_LEN - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(CF_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CF_DEPTH);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t            state;
  logic [BC_W-1:0]   burst_cnt;
  logic [OFF_W-1:0]  wr_off, rd_off;
  logic [FR_W-1:0]   wr_frame, rd_frame, last_done, rd_frame_sel;
  logic              last_valid;
  logic [CF_DEPTH-1:0] trk_we, trk_last;
  logic [PTR_W-1:0]  trk_wr_ptr, trk_rd_ptr;
  logic [CNT_W-1:0]  trk_cnt;
  logic              tracker_full, tracker_empty;
  logic              issue_ok, wh, rh, push, pop, leave;
  logic              unused_ok;

  // read_axis_ready is not needed: af already guarantees downstream space
  assign unused_ok = &{1'b0, read_axis_ready};

  assign tracker_full  = (trk_cnt == CNT_FULL);
  assign tracker_empty = (trk_cnt == '0);
  assign issue_ok      = !memrequest_busy && !tracker_full;
  assign wh            = (state == WR) && issue_ok && write_axis_valid;
  assign rh            = (state == RD) && issue_ok && !read_axis_af;
  assign push          = wh || rh;
  assign pop           = memrequest_complete && !tracker_empty;

  assign write_axis_ready        = (state == WR) && issue_ok;
  assign memrequest_en           = push;
  assign memrequest_write_enable = wh;
  assign memrequest_write_data   = wh ? write_axis_data : '0;

  // The first read of a frame must already use the newly latched frame.
  assign rd_frame_sel = (rd_off != '0) ? rd_frame : (last_valid ? last_done : '0);

  always_comb begin
    memrequest_addr = '0;
    case (state)
      WR: memrequest_addr = ADDR_WIDTH'(wr_frame) * ADDR_WIDTH'(FRAME_WORDS) + ADDR_WIDTH'(wr_off);
      RD: memrequest_addr = ADDR_WIDTH'(rd_frame_sel) * ADDR_WIDTH'(FRAME_WORDS) + ADDR_WIDTH'(rd_off);
      default: memrequest_addr = '0;
    endcase
  end

  // Yield on a full burst, or when idle here while the other side has work.
  always_comb begin
    leave = 1'b0;
    case (state)
      WR: leave = (wh && burst_cnt == BC_LAST) || (!write_axis_valid && !read_axis_af);
      RD: leave = (rh && burst_cnt == BC_LAST) || (read_axis_af && write_axis_valid);
      default: leave = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          state     <= RD;
          burst_cnt <= '0;
        end
        default: begin
          if (leave) begin
            state     <= (state == RD) ? WR : RD;
            burst_cnt <= '0;
          end else if (push) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_off     <= '0;
      wr_frame   <= '0;
      rd_off     <= '0;
      rd_frame   <= '0;
      last_done  <= '0;
      last_valid <= 1'b0;
    end else begin
      if (wh) begin
        if (write_axis_tlast) begin
          wr_off     <= '0;
          wr_frame   <= (wr_frame == FR_LAST) ? '0 : wr_frame + 1'b1;
          last_done  <= wr_frame;
          last_valid <= 1'b1;
        end else begin
          wr_off <= (wr_off == OFF_LAST) ? '0 : wr_off + 1'b1;
        end
      end
      if (rh) begin
        rd_frame <= rd_frame_sel;
        rd_off   <= (rd_off == OFF_LAST) ? '0 : rd_off + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_we     <= '0;
      trk_last   <= '0;
      trk_wr_ptr <= '0;
      trk_rd_ptr <= '0;
      trk_cnt    <= '0;
      cmd_error  <= 1'b0;
    end else begin
      if (push) begin
        trk_we[trk_wr_ptr]   <= wh;
        trk_last[trk_wr_ptr] <= rh && (rd_off == OFF_LAST);
        trk_wr_ptr           <= (trk_wr_ptr == PTR_LAST) ? '0 : trk_wr_ptr + 1'b1;
      end
      if (pop) begin
        trk_rd_ptr <= (trk_rd_ptr == PTR_LAST) ? '0 : trk_rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   trk_cnt <= trk_cnt + 1'b1;
        2'b01:   trk_cnt <= trk_cnt - 1'b1;
        default: trk_cnt <= trk_cnt;
      endcase
      if (memrequest_complete && tracker_empty) begin
        cmd_error <= 1'b1;
      end
    end
  end

  assign read_axis_valid = pop && !trk_we[trk_rd_ptr];
  assign read_axis_data  = memrequest_resp_data;
  assign read_axis_tlast = read_axis_valid && trk_last[trk_rd_ptr];

endmodule

// File: tb/tb_burst_traffic_generator.sv
// tb_burst_traffic_generator
// Small-geometry bench (4-word frames, 2 frames, bursts of 2, 4-deep
// tracker). A memory model completes every command 3 cycles after issue.
// Expected write/read commands and read-stream words are queued when the
// stimulus is set up and compared as the DUT produces them.
module tb_burst_traffic_generator;
  localparam int AW = 24;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] memrequest_addr;
  logic          memrequest_en;
  logic          memrequest_write_enable;
  logic [DW-1:0] memrequest_write_data;
  logic [DW-1:0] memrequest_resp_data = '0;
  logic          memrequest_complete = 1'b0;
  logic          memrequest_busy = 1'b0;
  logic [DW-1:0] write_axis_data = '0;
  logic          write_axis_tlast = 1'b0;
  logic          write_axis_valid = 1'b0;
  logic          write_axis_ready;
  logic [DW-1:0] read_axis_data;
  logic          read_axis_tlast;
  logic          read_axis_valid;
  logic          read_axis_af = 1'b1;
  logic          read_axis_ready = 1'b1;
  logic          cmd_error;

  burst_traffic_generator #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAME_WORDS(4),
    .NUM_FRAMES(2), .BURST_LEN(2), .CF_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .memrequest_addr(memrequest_addr), .memrequest_en(memrequest_en),
    .memrequest_write_enable(memrequest_write_enable),
    .memrequest_write_data(memrequest_write_data),
    .memrequest_resp_data(memrequest_resp_data),
    .memrequest_complete(memrequest_complete), .memrequest_busy(memrequest_busy),
    .write_axis_data(write_axis_data), .write_axis_tlast(write_axis_tlast),
    .write_axis_valid(write_axis_valid), .write_axis_ready(write_axis_ready),
    .read_axis_data(read_axis_data), .read_axis_tlast(read_axis_tlast),
    .read_axis_valid(read_axis_valid), .read_axis_af(read_axis_af),
    .read_axis_ready(read_axis_ready), .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    int            due;
    logic          we;
    logic [AW-1:0] addr;
  } pend_t;

  int            cyc = 0;
  pend_t         pend_q[$];
  logic [DW-1:0] mem [0:7];
  int            wr_iss_cnt = 0;
  int            rd_iss_cnt = 0;
  int            iss_cyc[$];
  logic          iss_we[$];
  logic [AW-1:0] exp_wr_addr[$];
  logic [DW-1:0] exp_wr_data[$];
  logic [AW-1:0] exp_rd_addr[$];
  logic [DW:0]   exp_out[$];
  logic          hold_cpl = 1'b0;
  int            cpl_allow = 0;
  int            cpl_done_cnt = 0;
  pend_t         mon_p;
  pend_t         drv_p;
  logic [DW:0]   mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  // memory model: completion 3 cycles after issue, optionally withheld
  always @(posedge clk) begin
    #1;
    memrequest_complete = 1'b0;
    memrequest_resp_data = '0;
    if (pend_q.size() > 0) begin
      if (pend_q[0].due <= cyc && (!hold_cpl || cpl_done_cnt < cpl_allow)) begin
        drv_p = pend_q.pop_front();
        memrequest_complete = 1'b1;
        memrequest_resp_data = drv_p.we ? '0 : mem[drv_p.addr[2:0]];
        cpl_done_cnt++;
      end
    end
  end

  // monitor / scoreboard consumer
  always @(negedge clk) begin
    if (memrequest_en) begin
      mon_p.due = cyc + 3;
      mon_p.we = memrequest_write_enable;
      mon_p.addr = memrequest_addr;
      pend_q.push_back(mon_p);
      iss_cyc.push_back(cyc);
      iss_we.push_back(memrequest_write_enable);
      if (memrequest_write_enable) begin
        wr_iss_cnt++;
        mem[memrequest_addr[2:0]] = memrequest_write_data;
        check_eq("wr_expected", exp_wr_addr.size() > 0, 1);
        if (exp_wr_addr.size() > 0) begin
          check_eq("wr_addr", memrequest_addr, exp_wr_addr.pop_front());
          check_eq("wr_data", memrequest_write_data, exp_wr_data.pop_front());
        end
      end else begin
        rd_iss_cnt++;
        check_eq("rd_wdata_zero", memrequest_write_data, 0);
        check_eq("rd_expected", exp_rd_addr.size() > 0, 1);
        if (exp_rd_addr.size() > 0) check_eq("rd_addr", memrequest_addr, exp_rd_addr.pop_front());
      end
    end
    if (read_axis_valid) begin
      check_eq("out_expected", exp_out.size() > 0, 1);
      if (exp_out.size() > 0) begin
        mon_e = exp_out.pop_front();
        check_eq("out_data", read_axis_data, mon_e[DW-1:0]);
        check_eq("out_tlast", read_axis_tlast, mon_e[DW]);
      end
    end
  end

  task automatic send_word(input logic [DW-1:0] d, input logic last, input logic [AW-1:0] a);
    int n;
    write_axis_data = d;
    write_axis_tlast = last;
    write_axis_valid = 1'b1;
    exp_wr_addr.push_back(a);
    exp_wr_data.push_back(d);
    n = 0;
    forever begin
      @(negedge clk);
      if (write_axis_ready) break;
      n++;
      if (n > 200) begin
        check_eq("wr_timeout", write_axis_ready, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", write_axis_ready, 0);
    check_eq("rst_en", memrequest_en, 0);
    check_eq("rst_valid", read_axis_valid, 0);
    check_eq("rst_cmd_error", cmd_error, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rel_ready", write_axis_ready, 0);
    check_eq("rel_en", memrequest_en, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (pend_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_pending", pend_q.size(), 0);
    repeat (3) @(negedge clk);
    check_eq("drain_exp_wr", exp_wr_addr.size(), 0);
    check_eq("drain_exp_rd", exp_rd_addr.size(), 0);
    check_eq("drain_exp_out", exp_out.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    for (int i = 0; i < 8; i++) mem[i] = '0;

    // Phase A: frame writes with af high, then interleaved read/write
    for (int i = 0; i < 4; i++) begin
      exp_rd_addr.push_back(AW'(i));
      exp_out.push_back({(i == 3), 32'hA000_0000 + i});
    end
    for (int i = 0; i < 4; i++) begin
      exp_rd_addr.push_back(AW'(4 + i));
      exp_out.push_back({(i == 3), 32'hB000_0004 + i});
    end
    write_axis_valid = 1'b1;
    write_axis_data = 32'hA000_0000;
    read_axis_af = 1'b1;
    do_reset();
    fork
      begin
        for (int i = 0; i < 4; i++) send_word(32'hA000_0000 + i, (i == 3), AW'(i));
        read_axis_af = 1'b0;
        for (int i = 0; i < 4; i++) send_word(32'hB000_0004 + i, (i == 3), AW'(4 + i));
        send_word(32'hC000_0000, 1'b0, AW'(0));
        send_word(32'hC000_0001, 1'b1, AW'(1));
        send_word(32'hD000_0004, 1'b0, AW'(4));
        write_axis_valid = 1'b0;
        write_axis_tlast = 1'b0;
      end
      begin
        n = 0;
        forever begin
          @(posedge clk);
          #1;
          if (rd_iss_cnt >= 8) begin
            read_axis_af = 1'b1;
            break;
          end
          n++;
          if (n > 300) begin
            check_eq("a_read_timeout", rd_iss_cnt, 8);
            read_axis_af = 1'b1;
            break;
          end
        end
      end
    join
    drain();
    check_eq("a_issue_count", iss_cyc.size(), 19);
    if (iss_cyc.size() >= 8) begin
      check_eq("a_first4_writes", {iss_we[0], iss_we[1], iss_we[2], iss_we[3]}, 4'b1111);
      check_eq("a_gap01", iss_cyc[1] - iss_cyc[0], 1);
      check_eq("a_gap12", iss_cyc[2] - iss_cyc[1], 2);
      check_eq("a_gap23", iss_cyc[3] - iss_cyc[2], 1);
      check_eq("a_order_rrww", {iss_we[4], iss_we[5], iss_we[6], iss_we[7]}, 4'b0011);
    end

    // Phase B: withheld completions fill the tracker
    read_axis_af = 1'b1;
    write_axis_valid = 1'b0;
    cpl_allow = cpl_done_cnt;
    hold_cpl = 1'b1;
    do_reset();
    base = wr_iss_cnt;
    fork
      begin
        for (int i = 0; i < 4; i++) send_word(32'hE000_0000 + i, 1'b0, AW'(i));
        send_word(32'hE000_0004, 1'b0, AW'(0));
        send_word(32'hE000_0005, 1'b0, AW'(1));
        write_axis_valid = 1'b0;
      end
      begin
        n = 0;
        while (wr_iss_cnt - base < 4 && n < 100) begin
          @(negedge clk);
          n++;
        end
        repeat (5) @(negedge clk);
        check_eq("b_full_ready", write_axis_ready, 0);
        check_eq("b_full_en", memrequest_en, 0);
        check_eq("b_full_count", wr_iss_cnt - base, 4);
        cpl_allow = cpl_done_cnt + 1;
        repeat (8) @(negedge clk);
        check_eq("b_one_slot_count", wr_iss_cnt - base, 5);
        check_eq("b_one_slot_ready", write_axis_ready, 0);
        hold_cpl = 1'b0;
      end
    join
    drain();

    // Phase C: reset with a command outstanding, then its late completion
    read_axis_af = 1'b1;
    do_reset();
    send_word(32'hF000_0000, 1'b0, AW'(0));
    rst = 1'b1;
    @(negedge clk);
    check_eq("c_rst_ready", write_axis_ready, 0);
    check_eq("c_rst_en", memrequest_en, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("c_rel_ready", write_axis_ready, 0);
    check_eq("c_rel_en", memrequest_en, 0);
    @(posedge clk);
    #1;
    write_axis_valid = 1'b0;
    @(negedge clk);
    check_eq("c_spurious_valid", read_axis_valid, 0);
    @(posedge clk);
    #1;
    check_eq("c_cmd_error_set", cmd_error, 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("c_cmd_error_async_clear", cmd_error, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("c_exp_wr_left", exp_wr_addr.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
